// File: rtl/bp_me_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : bp_me_wb_bridge
// Brief    : Round-robin multi-channel BedRock command to Wishbone B4 master;
//            block transfers become incrementing bursts. Optional abort on
//            missing ack via macro BP_WB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module bp_me_wb_bridge #(
  parameter int num_ch_p         = 2,
  parameter int paddr_width_p    = 40,
  parameter int block_width_p    = 512,
  parameter int wb_data_width_p  = 64,
  parameter int timeout_cycles_p = 1024
) (
  input  logic                                              clk_i,
  input  logic                                              reset_i,
  input  logic [num_ch_p-1:0]                               cmd_v_i,
  output logic [num_ch_p-1:0]                               cmd_ready_o,
  input  logic [num_ch_p-1:0]                               cmd_wr_i,
  input  logic [num_ch_p*3-1:0]                             cmd_size_i,
  input  logic [num_ch_p*paddr_width_p-1:0]                 cmd_addr_i,
  input  logic [num_ch_p*block_width_p-1:0]                 cmd_data_i,
  output logic [num_ch_p-1:0]                               resp_v_o,
  input  logic [num_ch_p-1:0]                               resp_yumi_i,
  output logic                                              resp_err_o,
  output logic [block_width_p-1:0]                          resp_data_o,
  output logic [paddr_width_p-$clog2(wb_data_width_p/8)-1:0] wbm_adr_o,
  output logic [wb_data_width_p-1:0]                        wbm_dat_o,
  input  logic [wb_data_width_p-1:0]                        wbm_dat_i,
  output logic [wb_data_width_p/8-1:0]                      wbm_sel_o,
  output logic                                              wbm_cyc_o,
  output logic                                              wbm_stb_o,
  output logic                                              wbm_we_o,
  output logic [2:0]                                        wbm_cti_o,
  output logic [1:0]                                        wbm_bte_o,
  input  logic                                              wbm_ack_i,
  input  logic                                              wbm_err_i
);

  localparam int c_wb_bytes  = wb_data_width_p / 8;
  localparam int c_wb_lg     = $clog2(c_wb_bytes);
  localparam int c_wadr_w    = paddr_width_p - c_wb_lg;
  localparam int c_max_beats = block_width_p / wb_data_width_p;
  localparam int c_beat_w    = (c_max_beats > 1) ? $clog2(c_max_beats) : 1;
  localparam int c_ch_w      = (num_ch_p > 1) ? $clog2(num_ch_p) : 1;
  localparam int c_off_w     = (c_wb_lg > 0) ? c_wb_lg : 1;
  localparam logic [2:0] c_wb_lg3   = 3'(c_wb_lg);
  localparam logic [2:0] c_max_size = 3'($clog2(block_width_p / 8));

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_bus  = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  logic [1:0]                 r_state, w_state_nxt;
  logic [c_ch_w-1:0]          r_ptr, r_ch, w_gnt_ch;
  logic                       w_gnt_v, w_accept, w_timeout;
  logic                       r_wr, r_err;
  logic [2:0]                 r_size, w_acc_size;
  logic [c_off_w-1:0]         r_off, w_lane_mask;
  logic [block_width_p-1:0]   r_data, r_resp_data;
  logic [c_wadr_w-1:0]        r_adr, w_acc_adr;
  logic [c_beat_w-1:0]        r_beat, r_last, w_acc_last;
  logic [paddr_width_p-1:0]   w_acc_addr;
  logic [c_wb_bytes-1:0]      w_sel;
  logic [wb_data_width_p-1:0] w_dat;
  logic [2:0]                 w_cti;

  // First requester at or above the pointer wins; descending scan lets the
  // nearest one overwrite the others.
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_ch = '0;
    for (int k = num_ch_p - 1; k >= 0; k--) begin
      if (cmd_v_i[(int'(r_ptr) + k) % num_ch_p]) begin
        w_gnt_v  = 1'b1;
        w_gnt_ch = c_ch_w'((int'(r_ptr) + k) % num_ch_p);
      end
    end
  end

  assign w_accept   = (r_state == c_idle) && w_gnt_v;
  assign w_acc_addr = cmd_addr_i[w_gnt_ch*paddr_width_p +: paddr_width_p];
  assign w_acc_size = (cmd_size_i[w_gnt_ch*3 +: 3] > c_max_size) ? c_max_size
                                                                  : cmd_size_i[w_gnt_ch*3 +: 3];

  always_comb begin
    w_acc_last = '0;
    if (w_acc_size > c_wb_lg3)
      w_acc_last = c_beat_w'((32'd1 << (w_acc_size - c_wb_lg3)) - 32'd1);
  end

  // Bursts start on a boundary of their own size.
  assign w_acc_adr = w_acc_addr[paddr_width_p-1:c_wb_lg] & ~(c_wadr_w'(w_acc_last));

`ifdef BP_WB_TIMEOUT_EN
  localparam int c_tmo_w = $clog2(timeout_cycles_p + 1);
  logic [c_tmo_w-1:0] r_tmo;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_tmo <= '0;
    else if (w_accept || wbm_ack_i || wbm_err_i)
      r_tmo <= '0;
    else if (r_state == c_bus)
      r_tmo <= r_tmo + 1'b1;
  end

  assign w_timeout = (r_state == c_bus) && !wbm_ack_i && !wbm_err_i &&
                     (r_tmo == c_tmo_w'(timeout_cycles_p - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      r_state <= c_idle;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle: if (w_gnt_v) w_state_nxt = c_bus;
      c_bus: begin
        if (wbm_err_i || w_timeout)
          w_state_nxt = c_resp;
        else if (wbm_ack_i && (r_beat == r_last))
          w_state_nxt = c_resp;
      end
      c_resp: if (resp_yumi_i[r_ch]) w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr       <= '0;
      r_ch        <= '0;
      r_wr        <= 1'b0;
      r_size      <= '0;
      r_off       <= '0;
      r_data      <= '0;
      r_adr       <= '0;
      r_beat      <= '0;
      r_last      <= '0;
      r_err       <= 1'b0;
      r_resp_data <= '0;
    end else if (w_accept) begin
      r_ptr       <= (int'(w_gnt_ch) == num_ch_p - 1) ? '0 : w_gnt_ch + 1'b1;
      r_ch        <= w_gnt_ch;
      r_wr        <= cmd_wr_i[w_gnt_ch];
      r_size      <= w_acc_size;
      r_off       <= w_acc_addr[c_off_w-1:0];
      r_data      <= cmd_data_i[w_gnt_ch*block_width_p +: block_width_p];
      r_adr       <= w_acc_adr;
      r_beat      <= '0;
      r_last      <= w_acc_last;
      r_err       <= 1'b0;
      r_resp_data <= '0;
    end else if (r_state == c_bus) begin
      if (wbm_err_i || w_timeout) begin
        r_err <= 1'b1;
      end else if (wbm_ack_i) begin
        if (!r_wr)
          r_resp_data[r_beat*wb_data_width_p +: wb_data_width_p] <= wbm_dat_i;
        r_beat <= r_beat + 1'b1;
        r_adr  <= r_adr + 1'b1;
      end
    end
  end

  // Sub-word beats select the aligned lane group and mirror the low bytes
  // of the command data into every lane.
  always_comb begin
    w_lane_mask = (c_off_w'(1) << r_size) - 1'b1;
    w_sel       = '1;
    w_dat       = r_data[r_beat*wb_data_width_p +: wb_data_width_p];
    if (r_size < c_wb_lg3) begin
      for (int j = 0; j < c_wb_bytes; j++) begin
        w_sel[j]        = (((c_off_w'(j) ^ r_off) >> r_size) == '0);
        w_dat[8*j +: 8] = r_data[8*(c_off_w'(j) & w_lane_mask) +: 8];
      end
    end
  end

  always_comb begin
    if (r_last == '0)
      w_cti = 3'b000;
    else if (r_beat == r_last)
      w_cti = 3'b111;
    else
      w_cti = 3'b010;
  end

  always_comb begin
    cmd_ready_o = '0;
    resp_v_o    = '0;
    resp_err_o  = 1'b0;
    wbm_cyc_o   = 1'b0;
    wbm_stb_o   = 1'b0;
    wbm_we_o    = 1'b0;
    wbm_sel_o   = '0;
    wbm_cti_o   = 3'b000;
    wbm_adr_o   = '0;
    wbm_dat_o   = '0;
    case (r_state)
      c_idle: if (w_gnt_v && !reset_i) cmd_ready_o[w_gnt_ch] = 1'b1;
      c_bus: begin
        wbm_cyc_o = 1'b1;
        wbm_stb_o = 1'b1;
        wbm_we_o  = r_wr;
        wbm_sel_o = w_sel;
        wbm_cti_o = w_cti;
        wbm_adr_o = r_adr;
        wbm_dat_o = w_dat;
      end
      c_resp: begin
        resp_v_o[r_ch] = 1'b1;
        resp_err_o     = r_err;
      end
      default: ;
    endcase
  end

  assign resp_data_o = r_resp_data;
  assign wbm_bte_o   = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_bp_me_wb_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_bp_me_wb_bridge
// Brief    : Directed self-checking bench for bp_me_wb_bridge with a scripted
//            Wishbone slave. Timeout case follows BP_WB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module tb_bp_me_wb_bridge;

  logic          clk = 1'b0;
  logic          reset_i;
  logic [1:0]    cmd_v, cmd_ready, cmd_wr, resp_v, resp_yumi;
  logic [5:0]    cmd_size;
  logic [79:0]   cmd_addr;
  logic [1023:0] cmd_data;
  logic          resp_err;
  logic [511:0]  resp_data;
  logic [36:0]   wbm_adr;
  logic [63:0]   wbm_dat_o, wbm_dat_i;
  logic [7:0]    wbm_sel;
  logic          wbm_cyc, wbm_stb, wbm_we, wbm_ack, wbm_err;
  logic [2:0]    wbm_cti;
  logic [1:0]    wbm_bte;

  always #5 clk = ~clk;

  bp_me_wb_bridge #(
    .num_ch_p(2), .paddr_width_p(40), .block_width_p(512),
    .wb_data_width_p(64), .timeout_cycles_p(16)
  ) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_wr_i(cmd_wr),
    .cmd_size_i(cmd_size), .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data),
    .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_err_o(resp_err),
    .resp_data_o(resp_data),
    .wbm_adr_o(wbm_adr), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_sel_o(wbm_sel), .wbm_cyc_o(wbm_cyc), .wbm_stb_o(wbm_stb),
    .wbm_we_o(wbm_we), .wbm_cti_o(wbm_cti), .wbm_bte_o(wbm_bte),
    .wbm_ack_i(wbm_ack), .wbm_err_i(wbm_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scripted slave: acks each beat after ack_delay extra stb cycles.
  int          ack_delay = 0;
  int          err_beat  = -1;
  logic        never_ack = 1'b0;
  logic [63:0] rdata [8];
  logic [36:0] adr_log [16];
  logic [7:0]  sel_log [16];
  logic [2:0]  cti_log [16];
  logic [63:0] dat_log [16];
  logic        we_log  [16];
  int          nb = 0, wcnt = 0, stb_cycles = 0, rr_viol = 0;

  always @(negedge clk) begin
    wbm_ack = 1'b0;
    wbm_err = 1'b0;
    if ($countones(cmd_ready) > 1) rr_viol++;
    if (wbm_cyc && wbm_stb) begin
      stb_cycles++;
      if (!never_ack) begin
        if (wcnt >= ack_delay) begin
          if (nb < 16) begin
            adr_log[nb] = wbm_adr;
            sel_log[nb] = wbm_sel;
            cti_log[nb] = wbm_cti;
            dat_log[nb] = wbm_dat_o;
            we_log[nb]  = wbm_we;
          end
          if (nb == err_beat) wbm_err = 1'b1;
          else begin
            wbm_ack   = 1'b1;
            wbm_dat_i = rdata[nb % 8];
          end
          nb++;
          wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic clear_log();
    nb = 0; wcnt = 0; stb_cycles = 0;
  endtask

  task automatic issue(input int ch, input logic wr, input logic [2:0] size,
                       input logic [39:0] addr, input logic [511:0] data);
    int t;
    clear_log();
    @(negedge clk);
    cmd_v[ch] = 1'b1;
    cmd_wr[ch] = wr;
    cmd_size[ch*3 +: 3] = size;
    cmd_addr[ch*40 +: 40] = addr;
    cmd_data[ch*512 +: 512] = data;
    #1;
    t = 0;
    while (!cmd_ready[ch] && t < 50) begin @(negedge clk); t++; end
    if (!cmd_ready[ch]) check("accept_bound", 1'b0, 1'b1);
    @(posedge clk);
    #1 cmd_v[ch] = 1'b0;
  endtask

  task automatic wait_resp(input int ch, input int limit);
    int t;
    t = 0;
    while (!resp_v[ch] && t < limit) begin @(negedge clk); t++; end
    if (!resp_v[ch]) check("resp_bound", 1'b0, 1'b1);
  endtask

  task automatic yumi(input int ch);
    resp_yumi[ch] = 1'b1;
    @(posedge clk);
    #1 resp_yumi = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [511:0] exp_data;
  int           rr_exp [4] = '{0, 1, 0, 1};
  int           got_ch, t;

  initial begin
    reset_i = 1'b1;
    cmd_v = 2'b11; cmd_wr = '0; cmd_size = '0; cmd_addr = '0; cmd_data = '0;
    resp_yumi = '0; wbm_ack = 1'b0; wbm_err = 1'b0; wbm_dat_i = '0;
    for (int i = 0; i < 8; i++) rdata[i] = 64'(i + 1);

    // Reset state, with requests pending
    #12;
    check("rst_cmd_ready", cmd_ready, 2'b00);
    check("rst_resp", {resp_v, resp_err}, 3'b000);
    check("rst_resp_data", resp_data, '0);
    check("rst_wb_ctl", {wbm_cyc, wbm_stb, wbm_we, wbm_sel, wbm_cti, wbm_bte}, '0);
    check("rst_wb_adr_dat", {wbm_adr, wbm_dat_o}, '0);
    cmd_v = '0;
    @(negedge clk);
    reset_i = 1'b0;

    // Single full-word read on channel 1
    ack_delay = 1;
    rdata[0] = 64'hDEAD_BEEF_0123_4567;
    issue(1, 1'b0, 3'd3, 40'h00_8000_0010, '0);
    wait_resp(1, 50);
    check("t1_beats", nb, 1);
    check("t1_adr", adr_log[0], 37'h1000_0002);
    check("t1_sel_cti_we", {sel_log[0], cti_log[0], we_log[0]}, {8'hFF, 3'b000, 1'b0});
    check("t1_resp_v", resp_v, 2'b10);
    check("t1_resp_data", resp_data, {448'd0, 64'hDEAD_BEEF_0123_4567});
    check("t1_err", resp_err, 1'b0);
    yumi(1);
    check("t1_idle_resp_v", resp_v, 2'b00);

    // 8-beat block read on channel 0
    ack_delay = 0;
    for (int i = 0; i < 8; i++) rdata[i] = 64'(i + 1);
    issue(0, 1'b0, 3'd6, 40'h00_8000_0040, '0);
    wait_resp(0, 50);
    check("t2_beats", nb, 8);
    for (int k = 0; k < 8; k++) begin
      check("t2_adr", adr_log[k], 37'h1000_0008 + 37'(k));
      check("t2_cti", cti_log[k], (k < 7) ? 3'b010 : 3'b111);
    end
    exp_data = '0;
    for (int k = 0; k < 8; k++) exp_data[64*k +: 64] = 64'(k + 1);
    check("t2_resp_data", resp_data, exp_data);
    check("t2_resp_v", resp_v, 2'b01);
    yumi(0);

    // Sub-word write with a slow slave
    ack_delay = 5;
    issue(0, 1'b1, 3'd2, 40'h00_8000_0004, {448'd0, 64'h1122_3344_AABB_CCDD});
    wait_resp(0, 50);
    check("t3_stb_cycles", stb_cycles, 6);
    check("t3_sel", sel_log[0], 8'hF0);
    check("t3_dat", dat_log[0], 64'hAABB_CCDD_AABB_CCDD);
    check("t3_adr_we_cti", {adr_log[0], we_log[0], cti_log[0]}, {37'h1000_0000, 1'b1, 3'b000});
    check("t3_resp_data", resp_data, '0);
    check("t3_err", resp_err, 1'b0);
    yumi(0);

    // Round robin with both channels permanently requesting
    do_reset();
    ack_delay = 0;
    clear_log();
    cmd_wr = 2'b00; cmd_size = {3'd3, 3'd3};
    cmd_addr = {40'h200, 40'h100};
    cmd_v = 2'b11;
    #1;
    for (int i = 0; i < 4; i++) begin
      t = 0;
      while (cmd_ready == 2'b00 && t < 50) begin @(negedge clk); t++; end
      got_ch = cmd_ready[1] ? 1 : 0;
      check("rr_grant", got_ch, rr_exp[i]);
      @(posedge clk);
      #1;
      wait_resp(got_ch, 50);
      yumi(got_ch);
    end
    cmd_v = 2'b00;
    check("rr_adr", {adr_log[0], adr_log[1], adr_log[2], adr_log[3]},
          {37'h20, 37'h40, 37'h20, 37'h40});
    check("rr_onehot", rr_viol, 0);

    // Bus error on beat 3 of a burst
    err_beat = 3;
    issue(0, 1'b0, 3'd6, 40'h00_8000_0080, '0);
    wait_resp(0, 50);
    check("t5_beats", nb, 4);
    check("t5_err", resp_err, 1'b1);
    check("t5_cyc_low", {wbm_cyc, wbm_stb}, 2'b00);
    exp_data = '0;
    for (int k = 0; k < 3; k++) exp_data[64*k +: 64] = 64'(k + 1);
    check("t5_resp_data", resp_data, exp_data);
    yumi(0);
    err_beat = -1;

    // Silent slave
    never_ack = 1'b1;
    issue(1, 1'b0, 3'd3, 40'h00_8000_0010, '0);
`ifdef BP_WB_TIMEOUT_EN
    wait_resp(1, 40);
    check("tmo_stb_cycles", stb_cycles, 16);
    check("tmo_err", resp_err, 1'b1);
    check("tmo_cyc_low", wbm_cyc, 1'b0);
    yumi(1);
    never_ack = 1'b0;
`else
    repeat (1000) @(negedge clk);
    check("hang_cyc_high", {wbm_cyc, wbm_stb}, 2'b11);
    check("hang_no_resp", resp_v, 2'b00);
    #2 reset_i = 1'b1;
    #1;
    check("async_rst_cyc", {wbm_cyc, wbm_stb}, 2'b00);
    @(negedge clk);
    reset_i = 1'b0;
    never_ack = 1'b0;
    repeat (5) @(negedge clk);
    check("async_rst_no_resp", resp_v, 2'b00);
`endif

    // Recovery after the silent-slave case
    rdata[0] = 64'h0BAD_F00D_CAFE_0001;
    issue(0, 1'b0, 3'd3, 40'h00_0000_0018, '0);
    wait_resp(0, 50);
    check("rec_resp", {resp_v, resp_err, resp_data[63:0]}, {2'b01, 1'b0, 64'h0BAD_F00D_CAFE_0001});
    yumi(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
